// File: rtl/buffer_port_arbiter_if.sv
// Single-port on-chip buffer port shared by compute-side bridges and the RAM macro.
interface single_port_ram_intf #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cs;
    logic                  oe;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  W_req;
    logic [DATA_WIDTH-1:0] W_data;
    logic [DATA_WIDTH-1:0] R_data;

    // Requester side: drives the command, receives read data.
    modport compute (
        output cs,
        output oe,
        output addr,
        output W_req,
        output W_data,
        input  R_data
    );

    // Memory side: consumes the command, returns read data.
    modport mem (
        input  cs,
        input  oe,
        input  addr,
        input  W_req,
        input  W_data,
        output R_data
    );
endinterface

// File: rtl/buffer_port_arbiter.sv
// Round-robin, burst-locking arbiter that shares one single-port buffer among
// CH_NUM channels and returns tagged read data to the issuing channel.
module buffer_port_arbiter #(
    parameter int unsigned CH_NUM     = 8,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned ID_W       = $clog2(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_NUM-1:0]     ch_req,
    input  logic [CH_NUM-1:0]     ch_we,
    input  logic [ADDR_WIDTH-1:0] ch_addr  [CH_NUM],
    input  logic [DATA_WIDTH-1:0] ch_wdata [CH_NUM],
    input  logic [CH_NUM-1:0]     ch_last,
    output logic [CH_NUM-1:0]     ch_gnt,
    output logic [CH_NUM-1:0]     ch_rvalid,
    output logic [DATA_WIDTH-1:0] ch_rdata,
    output logic [ID_W-1:0]       owner,
    output logic                  locked,
    single_port_ram_intf.compute  buff_intf
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic            win_found;
    logic [ID_W-1:0] acc_id;
    logic            accept;
    logic            acc_we;
    logic            acc_last;

    logic            tag_v  [RD_LAT];
    logic [ID_W-1:0] tag_id [RD_LAT];

    // Round-robin search starting one past the last burst winner.
    always_comb begin : p_search
        int unsigned     idx;
        logic [ID_W-1:0] cand;
        win_id    = '0;
        win_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= CH_NUM) begin
                idx = idx - CH_NUM;
            end
            cand = ID_W'(idx);
            if (!win_found && ch_req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Grant: winner in IDLE, owner only (mirroring its request) in LOCK.
    always_comb begin
        ch_gnt = '0;
        if (rst_n) begin
            if (state == IDLE) begin
                if (win_found) begin
                    ch_gnt[win_id] = 1'b1;
                end
            end else begin
                ch_gnt[owner] = ch_req[owner];
            end
        end
        acc_id   = (state == IDLE) ? win_id : owner;
        accept   = |(ch_req & ch_gnt);
        acc_we   = ch_we[acc_id];
        acc_last = ch_last[acc_id];
    end

    // Arbitration FSM: owner tracking, burst lock and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= ID_W'(CH_NUM - 1);
            owner  <= '0;
        end else if (accept) begin
            owner <= acc_id;
            if (acc_last) begin
                state  <= IDLE;
                rr_ptr <= acc_id;
            end else begin
                state <= LOCK;
            end
        end
    end

    assign locked = (state == LOCK);

    // Register the accepted beat onto the buffer port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buff_intf.cs     <= 1'b0;
            buff_intf.oe     <= 1'b0;
            buff_intf.W_req  <= 1'b0;
            buff_intf.addr   <= '0;
            buff_intf.W_data <= '0;
        end else begin
            buff_intf.cs    <= accept;
            buff_intf.oe    <= accept & ~acc_we;
            buff_intf.W_req <= accept & acc_we;
            if (accept) begin
                buff_intf.addr   <= ch_addr[acc_id];
                buff_intf.W_data <= ch_wdata[acc_id];
            end
        end
    end

    // Tag each issued command with its channel (owner still names it) and
    // route R_data to that channel when the tag leaves the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_v[i]  <= 1'b0;
                tag_id[i] <= '0;
            end
            ch_rvalid <= '0;
            ch_rdata  <= '0;
        end else begin
            tag_v[0]  <= buff_intf.cs & buff_intf.oe;
            tag_id[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            ch_rvalid <= '0;
            if (tag_v[RD_LAT-1]) begin
                ch_rvalid[tag_id[RD_LAT-1]] <= 1'b1;
                ch_rdata                    <= buff_intf.R_data;
            end
        end
    end

endmodule

// File: tb/tb_buffer_port_arbiter.sv
// Directed bench for buffer_port_arbiter: RD_LAT=1 instance for function,
// RD_LAT=3 instance for the reset-while-reads-in-flight case.
module tb_buffer_port_arbiter;

    localparam int unsigned CH = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] req, we, last;
    logic [AW-1:0] addr  [CH];
    logic [DW-1:0] wdata [CH];

    logic [CH-1:0] gnt1, rv1, gnt3, rv3;
    logic [DW-1:0] rd1, rd3;
    logic [2:0]    own1, own3;
    logic          lk1, lk3;

    single_port_ram_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bi1 ();
    single_port_ram_intf #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bi3 ();

    buffer_port_arbiter #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ch_req(req), .ch_we(we), .ch_addr(addr),
        .ch_wdata(wdata), .ch_last(last), .ch_gnt(gnt1), .ch_rvalid(rv1),
        .ch_rdata(rd1), .owner(own1), .locked(lk1), .buff_intf(bi1)
    );

    buffer_port_arbiter #(.CH_NUM(CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ch_req(req), .ch_we(we), .ch_addr(addr),
        .ch_wdata(wdata), .ch_last(last), .ch_gnt(gnt3), .ch_rvalid(rv3),
        .ch_rdata(rd3), .owner(own3), .locked(lk3), .buff_intf(bi3)
    );

    always #5 clk = ~clk;

    // Buffer models: 64 words, known contents on reset, RD_LAT-cycle read return.
    logic [DW-1:0] mem1 [64];
    logic [DW-1:0] mem3 [64];
    logic [DW-1:0] p3a, p3b;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 16'hA000 + 16'(i);
            mem1[16]   <= 16'hBEEF;
            bi1.R_data <= '0;
        end else begin
            if (bi1.cs && bi1.W_req) mem1[bi1.addr[5:0]] <= bi1.W_data;
            bi1.R_data <= (bi1.cs && bi1.oe) ? mem1[bi1.addr[5:0]] : 16'h0;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 16'hA000 + 16'(i);
            mem3[16]   <= 16'hBEEF;
            p3a        <= '0;
            p3b        <= '0;
            bi3.R_data <= '0;
        end else begin
            if (bi3.cs && bi3.W_req) mem3[bi3.addr[5:0]] <= bi3.W_data;
            p3a        <= (bi3.cs && bi3.oe) ? mem3[bi3.addr[5:0]] : 16'h0;
            p3b        <= p3a;
            bi3.R_data <= p3b;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One table row = one cycle of inputs (all reads) and expected outputs.
    typedef struct {
        logic [7:0] req;
        logic [7:0] last;
        logic [7:0] gnt;
        logic       cs;
        logic [2:0] own;
        logic       lk;
        logic [7:0] rv;
    } vec_t;

    vec_t tv [17];

    // Burst-lock sequence tables (ch1 writes, ch4 reads throughout).
    logic [7:0] b_req  [7] = '{8'h12, 8'h12, 8'h10, 8'h10, 8'h12, 8'h12, 8'h10};
    logic       b_last [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] b_gnt  [7] = '{8'h02, 8'h02, 8'h00, 8'h00, 8'h02, 8'h02, 8'h10};
    logic       b_cs   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       b_lk   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seen;
        int         bt;

        tv[0]  = '{8'h29, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00};
        tv[1]  = '{8'h29, 8'hFF, 8'h08, 1'b1, 3'd3, 1'b0, 8'h00};
        tv[2]  = '{8'h29, 8'hFF, 8'h20, 1'b1, 3'd5, 1'b0, 8'h01};
        tv[3]  = '{8'h29, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0, 8'h08};
        tv[4]  = '{8'h29, 8'hFF, 8'h08, 1'b1, 3'd3, 1'b0, 8'h20};
        tv[5]  = '{8'h29, 8'hFF, 8'h20, 1'b1, 3'd5, 1'b0, 8'h01};
        tv[6]  = '{8'h80, 8'hFF, 8'h80, 1'b1, 3'd7, 1'b0, 8'h08};
        tv[7]  = '{8'h81, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0, 8'h20};
        tv[8]  = '{8'h81, 8'hFF, 8'h80, 1'b1, 3'd7, 1'b0, 8'h80};
        tv[9]  = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd7, 1'b0, 8'h01};
        tv[10] = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd7, 1'b0, 8'h80};
        tv[11] = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd7, 1'b0, 8'h00};
        tv[12] = '{8'h04, 8'hFB, 8'h04, 1'b1, 3'd2, 1'b1, 8'h00};
        tv[13] = '{8'h05, 8'hFF, 8'h04, 1'b1, 3'd2, 1'b0, 8'h00};
        tv[14] = '{8'h01, 8'hFF, 8'h01, 1'b1, 3'd0, 1'b0, 8'h04};
        tv[15] = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h04};
        tv[16] = '{8'h00, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 8'h01};

        for (int i = 0; i < CH; i++) begin
            addr[i]  = AW'(4 * i + 1);
            wdata[i] = 16'h7700 + 16'(i);
        end
        req  = 8'h07;
        we   = '0;
        last = 8'hFF;

        // Reset values, with requests present while reset is held.
        repeat (2) @(negedge clk);
        #1;
        chk("rst gnt1", 32'(gnt1), 32'h0);
        chk("rst gnt3", 32'(gnt3), 32'h0);
        chk("rst owner", 32'(own1), 32'h0);
        chk("rst locked", 32'(lk1), 32'h0);
        chk("rst cs", 32'(bi1.cs), 32'h0);
        chk("rst oe", 32'(bi1.oe), 32'h0);
        chk("rst wreq", 32'(bi1.W_req), 32'h0);
        chk("rst addr", 32'(bi1.addr), 32'h0);
        chk("rst wdata", 32'(bi1.W_data), 32'h0);
        chk("rst rdata", 32'(rd1), 32'h0);
        chk("rst rvalid", 32'(rv1), 32'h0);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;

        // Single read: ch2 reads 0x00010, returns 0xBEEF at T+3.
        @(negedge clk);
        req     = 8'h04;
        addr[2] = 20'h00010;
        #1 chk("sr gnt", 32'(gnt1), 32'h04);
        @(posedge clk); #1;
        chk("sr cs", 32'(bi1.cs), 32'h1);
        chk("sr oe", 32'(bi1.oe), 32'h1);
        chk("sr addr", 32'(bi1.addr), 32'h10);
        @(negedge clk);
        req     = '0;
        addr[2] = AW'(9);
        @(posedge clk); #1;
        chk("sr rvalid T+2", 32'(rv1), 32'h0);
        @(posedge clk); #1;
        chk("sr rvalid T+3", 32'(rv1), 32'h04);
        chk("sr rdata", 32'(rd1), 32'hBEEF);

        // Table: round-robin, pointer wrap, short lock, read returns.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            req  = tv[k].req;
            last = tv[k].last;
            we   = '0;
            #1 chk($sformatf("tbl%0d gnt", k), 32'(gnt1), 32'(tv[k].gnt));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d cs", k), 32'(bi1.cs), 32'(tv[k].cs));
            chk($sformatf("tbl%0d oe", k), 32'(bi1.oe), 32'(tv[k].cs));
            chk($sformatf("tbl%0d wreq", k), 32'(bi1.W_req), 32'h0);
            chk($sformatf("tbl%0d owner", k), 32'(own1), 32'(tv[k].own));
            chk($sformatf("tbl%0d locked", k), 32'(lk1), 32'(tv[k].lk));
            chk($sformatf("tbl%0d rvalid", k), 32'(rv1), 32'(tv[k].rv));
            if (tv[k].cs)
                chk($sformatf("tbl%0d addr", k), 32'(bi1.addr), 32'(4 * tv[k].own + 1));
            if (tv[k].rv != 8'h00)
                chk($sformatf("tbl%0d rdata", k), 32'(rd1), 32'(16'hA000 + 16'(4 * oh_idx(tv[k].rv) + 1)));
        end
        last = 8'hFF;

        // Burst lock: ch1 four writes with a 2-cycle gap, ch4 waiting.
        do_reset();
        bt = 0;
        we = 8'h02;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req      = b_req[c];
            last     = 8'h10 | (b_last[c] ? 8'h02 : 8'h00);
            addr[1]  = AW'(32'h20 + bt);
            wdata[1] = 16'h5500 + 16'(bt);
            #1 chk($sformatf("bl%0d gnt", c), 32'(gnt1), 32'(b_gnt[c]));
            @(posedge clk); #1;
            chk($sformatf("bl%0d cs", c), 32'(bi1.cs), 32'(b_cs[c]));
            chk($sformatf("bl%0d locked", c), 32'(lk1), 32'(b_lk[c]));
            if (b_gnt[c] == 8'h02) begin
                chk($sformatf("bl%0d wreq", c), 32'(bi1.W_req), 32'h1);
                chk($sformatf("bl%0d addr", c), 32'(bi1.addr), 32'h20 + 32'(bt));
                chk($sformatf("bl%0d wdata", c), 32'(bi1.W_data), 32'h5500 + 32'(bt));
                chk($sformatf("bl%0d owner", c), 32'(own1), 32'h1);
                bt++;
            end
            if (b_gnt[c] == 8'h10) begin
                chk($sformatf("bl%0d owner", c), 32'(own1), 32'h4);
                chk($sformatf("bl%0d oe", c), 32'(bi1.oe), 32'h1);
                chk($sformatf("bl%0d wreq", c), 32'(bi1.W_req), 32'h0);
            end
        end
        chk("bl beats", 32'(bt), 32'h4);

        // Mixed: ch6 writes 0x1234 to addr 5, then reads it back.
        @(negedge clk);
        req      = 8'h40;
        we       = 8'h40;
        last     = 8'hFF;
        addr[6]  = AW'(5);
        wdata[6] = 16'h1234;
        #1 chk("mx wr gnt", 32'(gnt1), 32'h40);
        @(posedge clk); #1;
        chk("mx wr cs", 32'(bi1.cs), 32'h1);
        chk("mx wr wreq", 32'(bi1.W_req), 32'h1);
        chk("mx wr oe", 32'(bi1.oe), 32'h0);
        chk("mx wr addr", 32'(bi1.addr), 32'h5);
        chk("mx wr wdata", 32'(bi1.W_data), 32'h1234);
        chk("mx rv0", 32'(rv1), 32'h0);
        @(negedge clk);
        we = '0;
        #1 chk("mx rd gnt", 32'(gnt1), 32'h40);
        @(posedge clk); #1;
        chk("mx rd cs", 32'(bi1.cs), 32'h1);
        chk("mx rd oe", 32'(bi1.oe), 32'h1);
        chk("mx rd wreq", 32'(bi1.W_req), 32'h0);
        chk("mx rd addr", 32'(bi1.addr), 32'h5);
        chk("mx rv ch4", 32'(rv1), 32'h10);
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        chk("mx rv none", 32'(rv1), 32'h0);
        @(posedge clk); #1;
        chk("mx rv ch6", 32'(rv1), 32'h40);
        chk("mx rdata", 32'(rd1), 32'h1234);

        // Reset mid-flight on the RD_LAT=3 instance.
        do_reset();
        addr[6] = AW'(25);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req = 8'h07;
            #1 chk($sformatf("rf%0d gnt", c), 32'(gnt3), 32'h1 << c);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rf gnt3 in rst", 32'(gnt3), 32'h0);
        chk("rf gnt1 in rst", 32'(gnt1), 32'h0);
        chk("rf cs in rst", 32'(bi3.cs), 32'h0);
        chk("rf owner in rst", 32'(own3), 32'h0);
        chk("rf rdata in rst", 32'(rd3), 32'h0);
        seen = rv3;
        @(posedge clk); #1;
        seen = seen | rv3;
        @(negedge clk);
        rst_n = 1'b1;
        req   = '0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | rv3;
        end
        chk("rf no rvalid", 32'(seen), 32'h0);
        chk("rf locked", 32'(lk3), 32'h0);
        chk("rf rdata", 32'(rd3), 32'h0);
        @(negedge clk);
        req = 8'h06;
        #1;
        chk("rf next gnt3", 32'(gnt3), 32'h02);
        chk("rf next gnt1", 32'(gnt1), 32'h02);
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/buffer_port_arbiter.md
# buffer_port_arbiter

Registered, round-robin arbitrated bridge that lets `CH_NUM` compute channels share one single-port on-chip buffer through a `single_port_ram_intf.compute` port. It adds a per-channel valid/ready handshake, burst locking and tagged read-data return. Read data goes only to the channel that issued the read, after a fixed latency. It sits between the systolic-array feeders/drainers and each activation, weight or partial-sum buffer.

## Interface
Parameters:
- `CH_NUM`, 8: number of requesting channels (≥2).
- `ADDR_WIDTH`, 20: buffer word address width.
- `DATA_WIDTH`, 16: buffer word width.
- `RD_LAT`, 1: cycles from a read command on `buff_intf` to valid `buff_intf.R_data` (≥1).
- `ID_W`, `$clog2(CH_NUM)`: channel index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_req[CH_NUM]`  in  1  channel has a beat pending.
- `ch_we[CH_NUM]`  in  1  1 = write beat, 0 = read beat.
- `ch_addr[CH_NUM]`  in  ADDR_WIDTH  beat address.
- `ch_wdata[CH_NUM]`  in  DATA_WIDTH  write data.
- `ch_last[CH_NUM]`  in  1  final beat of a burst; 0 keeps the bus locked to this channel.
- `ch_gnt[CH_NUM]`  out  1  combinational ready; a beat is accepted on any cycle with `ch_req & ch_gnt`.
- `ch_rvalid[CH_NUM]`  out  1  one-hot pulse; read data returned to that channel.
- `ch_rdata`  out  DATA_WIDTH  returned read data, shared by all channels and qualified by `ch_rvalid`.
- `owner`  out  ID_W  current or last granted channel.
- `locked`  out  1  FSM is in LOCK.
- `buff_intf`  modport  `single_port_ram_intf.compute`  buffer port (`cs`, `oe`, `addr`, `W_req`, `W_data`, `R_data`).

## Operation
- FSM states: IDLE and LOCK.
- **IDLE.** Round-robin search over `ch_req`, starting at `rr_ptr+1` and wrapping at `CH_NUM-1 → 0`. At most one `ch_gnt` is high, and only for the winner. On acceptance:
  - `owner` ← winner.
  - If `ch_last=0`: go to LOCK.
  - If `ch_last=1`: stay in IDLE and set `rr_ptr` ← winner.
- **LOCK.** Only `ch_gnt[owner]` may be high, and it equals `ch_req[owner]`. Other channels stall.
  - If the owner drops `ch_req`, the bus idles (`cs=0`) and stays locked.
  - An accepted beat with `ch_last=1`: go to IDLE and set `rr_ptr` ← owner.
- **Command register.** An accepted beat is registered onto `buff_intf` the next cycle:
  - `cs=1`
  - `oe=~we`
  - `W_req=we` (1 = write)
  - `addr`, `W_data`
  
  With no accepted beat: `cs=0`, `oe=0`, `W_req=0`; `addr` and `W_data` hold their previous values.
- **Read tag pipeline.** Each read command pushes {valid, id} into an `RD_LAT`-deep shift register. Writes push valid=0. When a valid tag exits, `R_data` is registered into `ch_rdata` and `ch_rvalid[id]` pulses for 1 cycle.
- **Ordering.** Return order equals issue order. A channel's reads and writes reach the buffer in acceptance order.
- **Throughput.** One beat per cycle, including back-to-back beats from different channels in IDLE.

## Timing
- Reset values (asynchronous assert; effective from the first rising edge after release):
  - state = IDLE, `rr_ptr` = `CH_NUM-1` (so channel 0 has first priority), `owner` = 0, `locked` = 0.
  - `cs`, `oe`, `W_req` = 0; `addr`, `W_data`, `ch_rdata` = 0.
  - All tags invalid; all `ch_rvalid` = 0.
- `ch_gnt` is combinational from `ch_req`, state, `owner` and `rr_ptr`. It is 0 for every channel while `rst_n=0`.
- Read latency: beat accepted at cycle T → command on `buff_intf` at T+1 → `ch_rvalid`/`ch_rdata` at T+2+`RD_LAT`. With `RD_LAT=1` this is T+3.
- Write: command on the buffer at T+1; there is no completion pulse.
- Reset mid-operation: in-flight tags are discarded and no `ch_rvalid` fires after reset. A held lock is released.
- Simultaneous exit of a tag and a new read acceptance is legal; the pipeline never stalls.
- `ch_addr`, `ch_we`, `ch_wdata` and `ch_last` are sampled only on acceptance.

## Test plan
- **Single read.** Reset; ch2 reads addr 0x00010, buffer model returns 0xBEEF with `RD_LAT=1`. Required: `ch_gnt[2]` at T, `cs=1, oe=1, addr=0x00010` at T+1, `ch_rvalid[2]=1` and `ch_rdata=0xBEEF` at T+3, no other `ch_rvalid`.
- **Round-robin fairness.** ch0, ch3 and ch5 hold single-beat reads continuously. Required grant order: 0, 3, 5, 0, 3, 5, one per cycle with no idle cycles. Returned ids follow the same order.
- **Burst lock.** ch1 issues 4 writes (`ch_last` on the 4th) while ch4 requests throughout. ch1 drops `ch_req` for 2 cycles mid-burst. Required: ch4 is not granted until the cycle after ch1's last beat; `cs=0` for the 2 gap cycles; `locked=1` throughout the burst.
- **Mixed read/write ordering.** ch6 writes 0x1234 to addr 5, then immediately reads addr 5. Required: the write command precedes the read command by 1 cycle; the read returns 0x1234 to ch6.
- **Reset mid-flight.** With `RD_LAT=3`, issue 3 reads, then pulse `rst_n` low for 1 cycle before any return. Required: all outputs are at reset values, no `ch_rvalid` pulse ever occurs, and the next grant goes to the lowest-indexed requester.
- **Pointer wrap.** `CH_NUM=8`: ch7 is granted, then ch7 and ch0 both request. Required: ch0 is granted next, then ch7.
